// File: rtl/fill_sequencer_if.sv
// Command and datapath handshake bundle between a host/fill datapath and fill_sequencer.
// The sequencer uses the slave modport; the host/datapath side uses master.
interface fill_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_coordinates;
    logic [47:0] coordinates;
    logic        math_start;
    logic        row_start;
    logic        fill_start;
    logic        math_done;
    logic        row_done;
    logic        fill_done;
    logic [8:0]  ymin;
    logic [8:0]  ymax;
    logic [8:0]  row_y;
    logic        busy;
    logic        all_finish;
    logic        error;

    modport master (
        output cmd_valid, cmd_coordinates, math_done, row_done, fill_done, ymin, ymax,
        input  cmd_ready, coordinates, math_start, row_start, fill_start, row_y,
               busy, all_finish, error
    );

    modport slave (
        input  cmd_valid, cmd_coordinates, math_done, row_done, fill_done, ymin, ymax,
        output cmd_ready, coordinates, math_start, row_start, fill_start, row_y,
               busy, all_finish, error
    );
endinterface

// File: rtl/fill_sequencer.sv
// Row-by-row fill sequencer: math phase, then a row/fill phase pair per scanline.
// Optional watchdog (ERR state, error flag) enabled by defining FILL_SEQ_TIMEOUT_EN.
module fill_sequencer #(
    parameter int MAX_Y       = 479,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic            clk,
    input  logic            n_rst,
    fill_sequencer_if.slave bus
);

    if (MAX_Y < 0 || MAX_Y > 511) begin : g_bad_max_y
        $error("fill_sequencer: MAX_Y must fit in 9 bits");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("fill_sequencer: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        MATH_WAIT,
        ROW_WAIT,
        FILL_WAIT,
        DONE
`ifdef FILL_SEQ_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    localparam logic [8:0] MAX_Y_ROW = 9'(MAX_Y);

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [47:0] coords_q, coords_d;
    logic [8:0]  row_y_q, row_y_d;
    logic [8:0]  last_y_q, last_y_d;
    logic        math_start_q, math_start_d;
    logic        row_start_q, row_start_d;
    logic        fill_start_q, fill_start_d;
    logic [8:0]  clamped_ymax;
    logic        accept;

`ifdef FILL_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
    logic             waiting;
`endif

    assign clamped_ymax = (bus.ymax > MAX_Y_ROW) ? MAX_Y_ROW : bus.ymax;
    assign accept       = bus.cmd_valid && ready_q;

    always_comb begin
        state_d      = state_q;
        coords_d     = coords_q;
        row_y_d      = row_y_q;
        last_y_d     = last_y_q;
        math_start_d = 1'b0;
        row_start_d  = 1'b0;
        fill_start_d = 1'b0;
`ifdef FILL_SEQ_TIMEOUT_EN
        error_d      = error_q;
        waiting      = (state_q == MATH_WAIT) || (state_q == ROW_WAIT) || (state_q == FILL_WAIT);
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    coords_d     = bus.cmd_coordinates;
                    math_start_d = 1'b1;
                    state_d      = MATH_WAIT;
`ifdef FILL_SEQ_TIMEOUT_EN
                    error_d      = 1'b0;
`endif
                end
            end
            MATH_WAIT: begin
                if (bus.math_done) begin
                    last_y_d = clamped_ymax;
                    row_y_d  = bus.ymin;
                    if (bus.ymin > clamped_ymax) begin
                        state_d = DONE;
                    end else begin
                        row_start_d = 1'b1;
                        state_d     = ROW_WAIT;
                    end
                end
            end
            ROW_WAIT: begin
                if (bus.row_done) begin
                    fill_start_d = 1'b1;
                    state_d      = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                // Compare before incrementing so row_y can never wrap past last_y.
                if (bus.fill_done) begin
                    if (row_y_q == last_y_q) begin
                        state_d = DONE;
                    end else begin
                        row_y_d     = row_y_q + 9'd1;
                        row_start_d = 1'b1;
                        state_d     = ROW_WAIT;
                    end
                end
            end
            DONE: state_d = IDLE;
`ifdef FILL_SEQ_TIMEOUT_EN
            ERR:  state_d = DONE;
`endif
            default: state_d = IDLE;
        endcase
`ifdef FILL_SEQ_TIMEOUT_EN
        // A timeout only fires when no done moved the FSM, so no start pulse is lost.
        if (waiting && (state_d == state_q) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
            state_d = ERR;
            error_d = 1'b1;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`endif
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            coords_q     <= '0;
            row_y_q      <= '0;
            last_y_q     <= '0;
            math_start_q <= 1'b0;
            row_start_q  <= 1'b0;
            fill_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            coords_q     <= coords_d;
            row_y_q      <= row_y_d;
            last_y_q     <= last_y_d;
            math_start_q <= math_start_d;
            row_start_q  <= row_start_d;
            fill_start_q <= fill_start_d;
        end
    end

`ifdef FILL_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.cmd_ready   = ready_q;
    assign bus.coordinates = coords_q;
    assign bus.row_y       = row_y_q;
    assign bus.math_start  = math_start_q;
    assign bus.row_start   = row_start_q;
    assign bus.fill_start  = fill_start_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.all_finish  = (state_q == DONE);

endmodule

// File: tb/tb_fill_sequencer.sv
// Self-checking bench for fill_sequencer: table-driven commands plus hand-written
// stray-done, mid-command reset and watchdog sequences (watchdog needs FILL_SEQ_TIMEOUT_EN).
module tb_fill_sequencer;

    logic clk;
    logic n_rst;

    fill_sequencer_if sb();

    fill_sequencer #(.MAX_Y(479), .TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host / datapath model variables
    logic        cmd_valid;
    logic [47:0] cmd_coords;
    logic [8:0]  drv_ymin, drv_ymax;
    logic        math_done_auto, row_done_auto, fill_done_auto;
    logic        row_done_man, fill_done_man;
    logic        math_en, row_en, fill_en;
    int          math_pend, row_pend, fill_pend;

    assign sb.cmd_valid       = cmd_valid;
    assign sb.cmd_coordinates = cmd_coords;
    assign sb.ymin            = drv_ymin;
    assign sb.ymax            = drv_ymax;
    assign sb.math_done       = math_done_auto;
    assign sb.row_done        = row_done_auto | row_done_man;
    assign sb.fill_done       = fill_done_auto | fill_done_man;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          last_done_cyc = 0;
    int          math_cnt, row_cnt, fill_cnt, fin_cnt;
    logic [8:0]  exp_row;
    logic [47:0] fin_coords;
    logic        fin_error;
    logic        chk_latency = 1'b1;

    typedef struct {
        logic [47:0] coords;
        logic [8:0]  ymin;
        logic [8:0]  ymax;
        int          exp_rows;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Datapath responder: each done returns 3 cycles after its start pulse.
    always @(negedge clk) begin
        math_done_auto = 1'b0;
        row_done_auto  = 1'b0;
        fill_done_auto = 1'b0;
        if (!n_rst) begin
            math_pend = 0;
            row_pend  = 0;
            fill_pend = 0;
        end else begin
            if (math_pend > 0) begin math_pend--; if (math_pend == 0) math_done_auto = 1'b1; end
            if (row_pend > 0)  begin row_pend--;  if (row_pend == 0)  row_done_auto  = 1'b1; end
            if (fill_pend > 0) begin fill_pend--; if (fill_pend == 0) fill_done_auto = 1'b1; end
            if (sb.math_start && math_en) math_pend = 3;
            if (sb.row_start && row_en)   row_pend  = 3;
            if (sb.fill_start && fill_en) fill_pend = 3;
        end
    end

    // Done inputs that can lead into DONE, timestamped when the DUT samples them.
    always @(posedge clk) begin
        if (n_rst && (sb.math_done || sb.fill_done)) last_done_cyc = cyc;
    end

    // Output monitor: pulse counts, row sequence, one-hot starts, finish behaviour.
    always @(negedge clk) begin
        cyc++;
        if (n_rst) begin
            if (sb.math_start) math_cnt++;
            if (sb.row_start) begin
                checkOutput("row_y_at_row_start", 64'(sb.row_y), 64'(exp_row));
                exp_row = exp_row + 9'd1;
                row_cnt++;
            end
            if (sb.fill_start) fill_cnt++;
            if (sb.math_start || sb.row_start || sb.fill_start)
                checkOutput("start_onehot",
                            64'({1'b0, sb.math_start} + {1'b0, sb.row_start} + {1'b0, sb.fill_start}), 64'd1);
            if (sb.all_finish) begin
                fin_cnt++;
                fin_coords = sb.coordinates;
                fin_error  = sb.error;
                checkOutput("ready_low_in_done", 64'(sb.cmd_ready), 64'd0);
                checkOutput("busy_in_done", 64'(sb.busy), 64'd1);
                if (chk_latency) checkOutput("finish_latency", 64'(cyc - last_done_cyc), 64'd1);
            end
        end
    end

    task automatic clear_counts(input logic [8:0] first_row);
        math_cnt = 0;
        row_cnt  = 0;
        fill_cnt = 0;
        fin_cnt  = 0;
        exp_row  = first_row;
    endtask

    task automatic startCmd(input logic [47:0] coords, input logic [8:0] ymin, input logic [8:0] ymax);
        int t;
        drv_ymin = ymin;
        drv_ymax = ymax;
        clear_counts(ymin);
        t = 0;
        while (!sb.cmd_ready && t < 50) begin @(negedge clk); #1; t++; end
        checkOutput("cmd_ready_before_accept", 64'(sb.cmd_ready), 64'd1);
        cmd_coords = coords;
        cmd_valid  = 1'b1;
        @(negedge clk); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic waitFinish(input int budget);
        int t;
        t = 0;
        while (fin_cnt == 0 && t < budget) begin @(negedge clk); #1; t++; end
        checkOutput("all_finish_seen", 64'(fin_cnt), 64'd1);
        @(negedge clk); #1;
        checkOutput("cmd_ready_after_finish", 64'(sb.cmd_ready), 64'd1);
        checkOutput("busy_after_finish", 64'(sb.busy), 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        startCmd(v.coords, v.ymin, v.ymax);
        waitFinish(2000);
        checkOutput("math_start_count", 64'(math_cnt), 64'd1);
        checkOutput("row_start_count", 64'(row_cnt), 64'(v.exp_rows));
        checkOutput("fill_start_count", 64'(fill_cnt), 64'(v.exp_rows));
        checkOutput("coords_held", 64'(fin_coords), 64'(v.coords));
    endtask

    task automatic wait_until_count(input string name, ref int cnt, input int target);
        int t;
        t = 0;
        while (cnt < target && t < 200) begin @(negedge clk); #1; t++; end
        checkOutput(name, 64'(cnt), 64'(target));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        vecs[0] = '{48'hFFFF1212EEEE, 9'd10,  9'd12,  3};
        vecs[1] = '{48'h0123456789AB, 9'd20,  9'd5,   0};
        vecs[2] = '{48'hA5A55A5A0F0F, 9'd478, 9'd500, 2};
        vecs[3] = '{48'h000000000001, 9'd7,   9'd7,   1};
        vecs[4] = '{48'h800000000000, 9'd0,   9'd0,   1};
        vecs[5] = '{48'h5555AAAA5555, 9'd500, 9'd510, 0};

        cmd_valid     = 1'b0;
        cmd_coords    = '0;
        drv_ymin      = '0;
        drv_ymax      = '0;
        row_done_man  = 1'b0;
        fill_done_man = 1'b0;
        math_en       = 1'b1;
        row_en        = 1'b1;
        fill_en       = 1'b1;
        clear_counts(9'd0);

        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        checkOutput("reset_coordinates", 64'(sb.coordinates), 64'd0);
        checkOutput("reset_row_y", 64'(sb.row_y), 64'd0);
        checkOutput("reset_starts", 64'({sb.math_start, sb.row_start, sb.fill_start}), 64'd0);
        checkOutput("reset_busy", 64'(sb.busy), 64'd0);
        checkOutput("reset_all_finish", 64'(sb.all_finish), 64'd0);
        checkOutput("reset_error", 64'(sb.error), 64'd0);
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk); #1;
        checkOutput("ready_after_reset", 64'(sb.cmd_ready), 64'd1);

        $display("[TB] table-driven commands");
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        $display("[TB] stray fill_done during ROW_WAIT");
        row_en = 1'b0;
        startCmd(48'h0000FFFF0000, 9'd30, 9'd31);
        wait_until_count("stray_row_start_seen", row_cnt, 1);
        fill_done_man = 1'b1;
        @(negedge clk); #1;
        fill_done_man = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("stray_no_fill_start", 64'(fill_cnt), 64'd0);
        checkOutput("stray_no_finish", 64'(fin_cnt), 64'd0);
        checkOutput("stray_busy", 64'(sb.busy), 64'd1);
        row_done_man = 1'b1;
        @(negedge clk); #1;
        row_done_man = 1'b0;
        checkOutput("stray_fill_start_after_row_done", 64'(sb.fill_start), 64'd1);
        row_en = 1'b1;
        waitFinish(500);
        checkOutput("stray_rows", 64'(row_cnt), 64'd2);
        checkOutput("stray_fills", 64'(fill_cnt), 64'd2);

        $display("[TB] reset during FILL_WAIT");
        startCmd(48'hDEADBEEF0001, 9'd40, 9'd45);
        wait_until_count("midreset_fill_start_seen", fill_cnt, 1);
        n_rst = 1'b0;
        #1;
        checkOutput("midreset_coordinates", 64'(sb.coordinates), 64'd0);
        checkOutput("midreset_row_y", 64'(sb.row_y), 64'd0);
        checkOutput("midreset_starts", 64'({sb.math_start, sb.row_start, sb.fill_start}), 64'd0);
        checkOutput("midreset_busy", 64'(sb.busy), 64'd0);
        checkOutput("midreset_all_finish", 64'(sb.all_finish), 64'd0);
        checkOutput("midreset_error", 64'(sb.error), 64'd0);
        checkOutput("midreset_ready", 64'(sb.cmd_ready), 64'd0);
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("midreset_no_finish", 64'(fin_cnt), 64'd0);
        applyStimulus(vecs[0]);

`ifdef FILL_SEQ_TIMEOUT_EN
        $display("[TB] watchdog with row_done withheld");
        row_en      = 1'b0;
        chk_latency = 1'b0;
        startCmd(48'h111122223333, 9'd50, 9'd50);
        waitFinish(200);
        checkOutput("wd_error_at_finish", 64'(fin_error), 64'd1);
        checkOutput("wd_error_sticky", 64'(sb.error), 64'd1);
        checkOutput("wd_no_fill_start", 64'(fill_cnt), 64'd0);
        checkOutput("wd_row_starts", 64'(row_cnt), 64'd1);
        row_en      = 1'b1;
        chk_latency = 1'b1;
        startCmd(48'h444455556666, 9'd60, 9'd60);
        checkOutput("wd_error_cleared_on_accept", 64'(sb.error), 64'd0);
        waitFinish(500);
        checkOutput("wd_next_cmd_rows", 64'(row_cnt), 64'd1);
        checkOutput("wd_next_cmd_error", 64'(fin_error), 64'd0);
`else
        $display("[TB] unbounded wait with row_done withheld");
        row_en = 1'b0;
        startCmd(48'h111122223333, 9'd50, 9'd50);
        repeat (40) @(negedge clk);
        #1;
        checkOutput("nowd_no_finish", 64'(fin_cnt), 64'd0);
        checkOutput("nowd_error", 64'(sb.error), 64'd0);
        checkOutput("nowd_busy", 64'(sb.busy), 64'd1);
        row_done_man = 1'b1;
        @(negedge clk); #1;
        row_done_man = 1'b0;
        row_en = 1'b1;
        waitFinish(500);
        checkOutput("nowd_fills", 64'(fill_cnt), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
